// File: rtl/sd_pkg.sv
// rtl/sd_pkg.sv - shared constants for the SD DAT0 block writer
// State encoding, result codes, CRC-status tokens and the CRC16 polynomial.
package sd_pkg;

  localparam logic [3:0] ST_IDLE  = 4'd0;
  localparam logic [3:0] ST_PRE   = 4'd1;
  localparam logic [3:0] ST_START = 4'd2;
  localparam logic [3:0] ST_DATA  = 4'd3;
  localparam logic [3:0] ST_CRC   = 4'd4;
  localparam logic [3:0] ST_ENDB  = 4'd5;
  localparam logic [3:0] ST_SWAIT = 4'd6;
  localparam logic [3:0] ST_STAT  = 4'd7;
  localparam logic [3:0] ST_BUSY  = 4'd8;
  localparam logic [3:0] ST_DONE  = 4'd9;

  typedef enum logic [1:0] {
    WSTAT_OK      = 2'd0,
    WSTAT_CRC     = 2'd1,
    WSTAT_WERR    = 2'd2,
    WSTAT_TIMEOUT = 2'd3
  } wstat_e;

  localparam logic [2:0]  TOK_ACCEPT  = 3'b010;
  localparam logic [2:0]  TOK_CRC_ERR = 3'b101;
  localparam logic [2:0]  TOK_WR_ERR  = 3'b110;

  localparam logic [15:0] CRC16_POLY  = 16'h1021;
  localparam int          DATA_BITS   = 4096;

endpackage

// File: rtl/sd_crc16.sv
// rtl/sd_crc16.sv - bit-serial CRC16 (x^16+x^12+x^5+1), zero initial value
// clr has priority over en; one data bit is absorbed per enabled clk.
module sd_crc16 (
  input  logic        clk,
  input  logic        rstn,
  input  logic        clr,
  input  logic        en,
  input  logic        din,
  output logic [15:0] crc
);
  import sd_pkg::*;

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    fb    = crc_q[15] ^ din;
    crc_d = crc_q;
    if (clr) begin
      crc_d = '0;
    end else if (en) begin
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC16_POLY : 16'h0000);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      crc_q <= '0;
    end else begin
      crc_q <= crc_d;
    end
  end

  assign crc = crc_q;

endmodule

// File: rtl/sd_dat_writer.sv
// rtl/sd_dat_writer.sv - single-bit DAT0 sector writer with CRC status and busy wait
// DAT0 is driven on sdclk falls and sampled on sdclk rises, both seen through a clk-registered copy.
module sd_dat_writer #(
  parameter int BUSY_TIMEOUT = 1000000,
  parameter int STAT_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       sdclk,
  input  logic       sddat0_in,
  output logic       sddat0_out,
  output logic       sddat0_oe,
  input  logic       wstart,
  output logic       wbusy,
  output logic       wdone,
  output logic [1:0] wstat,
  output logic [8:0] inaddr,
  input  logic [7:0] inbyte
);
  import sd_pkg::*;

  localparam int TMAX = (BUSY_TIMEOUT > STAT_TIMEOUT) ? BUSY_TIMEOUT : STAT_TIMEOUT;
  localparam int TW   = $clog2(TMAX + 1) + 1;

  logic          sdclkl_q, sdclkl_d;
  logic [3:0]    state_q, state_d;
  logic [11:0]   bcnt_q, bcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [7:0]    sr_q, sr_d;
  logic [2:0]    tok_q, tok_d;
  logic [8:0]    inaddr_q, inaddr_d;
  logic          out_q, out_d;
  logic          oe_q, oe_d;
  wstat_e        wstat_q, wstat_d;

  logic          rise, fall;
  logic          byte_load, dbit;
  logic          crc_clr, crc_en;
  logic [15:0]   crc;

  sd_crc16 u_crc (
    .clk  (clk),
    .rstn (rstn),
    .clr  (crc_clr),
    .en   (crc_en),
    .din  (dbit),
    .crc  (crc)
  );

  always_comb begin
    sdclkl_d  = sdclk;
    rise      = ~sdclkl_q & sdclk;
    fall      = sdclkl_q & ~sdclk;
    // Byte k>=1 is taken straight from inbyte for its MSB; the rest comes from the shifter.
    byte_load = (bcnt_q[2:0] == 3'd0) && (bcnt_q != 12'd0);
    dbit      = byte_load ? inbyte[7] : sr_q[7];

    state_d  = state_q;
    bcnt_d   = bcnt_q;
    tcnt_d   = tcnt_q;
    sr_d     = sr_q;
    tok_d    = tok_q;
    inaddr_d = inaddr_q;
    out_d    = out_q;
    oe_d     = oe_q;
    wstat_d  = wstat_q;
    crc_clr  = 1'b0;
    crc_en   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (wstart) begin
          inaddr_d = '0;
          crc_clr  = 1'b1;
          bcnt_d   = '0;
          tcnt_d   = '0;
          wstat_d  = WSTAT_OK;
          state_d  = ST_PRE;
        end
      end
      ST_PRE: begin
        if (fall) begin
          oe_d   = 1'b1;
          out_d  = 1'b1;
          bcnt_d = bcnt_q + 12'd1;
          if (bcnt_q == 12'd1) begin
            bcnt_d  = '0;
            state_d = ST_START;
          end
        end
      end
      ST_START: begin
        if (fall) begin
          out_d    = 1'b0;
          sr_d     = inbyte;
          inaddr_d = 9'd1;
          bcnt_d   = '0;
          state_d  = ST_DATA;
        end
      end
      ST_DATA: begin
        if (fall) begin
          out_d  = dbit;
          crc_en = 1'b1;
          sr_d   = byte_load ? {inbyte[6:0], 1'b0} : {sr_q[6:0], 1'b0};
          if (byte_load) begin
            inaddr_d = inaddr_q + 9'd1;
          end
          bcnt_d = bcnt_q + 12'd1;
          if (bcnt_q == 12'(DATA_BITS - 1)) begin
            bcnt_d  = '0;
            state_d = ST_CRC;
          end
        end
      end
      ST_CRC: begin
        if (fall) begin
          out_d  = crc[4'd15 - bcnt_q[3:0]];
          bcnt_d = bcnt_q + 12'd1;
          if (bcnt_q == 12'd15) begin
            bcnt_d  = '0;
            state_d = ST_ENDB;
          end
        end
      end
      ST_ENDB: begin
        // First fall drives the end bit, the second releases the line.
        if (fall) begin
          out_d = 1'b1;
          if (bcnt_q == 12'd0) begin
            bcnt_d = 12'd1;
          end else begin
            oe_d    = 1'b0;
            bcnt_d  = '0;
            tcnt_d  = '0;
            state_d = ST_SWAIT;
          end
        end
      end
      ST_SWAIT: begin
        if (rise) begin
          if (!sddat0_in) begin
            bcnt_d  = '0;
            state_d = ST_STAT;
          end else if (tcnt_q == TW'(STAT_TIMEOUT - 1)) begin
            wstat_d = WSTAT_TIMEOUT;
            state_d = ST_DONE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_STAT: begin
        if (rise) begin
          if (bcnt_q < 12'd3) begin
            tok_d  = {tok_q[1:0], sddat0_in};
            bcnt_d = bcnt_q + 12'd1;
          end else begin
            bcnt_d = '0;
            tcnt_d = '0;
            case (tok_q)
              TOK_ACCEPT: state_d = ST_BUSY;
              TOK_CRC_ERR: begin
                wstat_d = WSTAT_CRC;
                state_d = ST_DONE;
              end
              TOK_WR_ERR: begin
                wstat_d = WSTAT_WERR;
                state_d = ST_DONE;
              end
              default: begin
                wstat_d = WSTAT_WERR;
                state_d = ST_DONE;
              end
            endcase
          end
        end
      end
      ST_BUSY: begin
        if (rise) begin
          if (sddat0_in) begin
            wstat_d = WSTAT_OK;
            state_d = ST_DONE;
          end else if (tcnt_q == TW'(BUSY_TIMEOUT)) begin
            wstat_d = WSTAT_TIMEOUT;
            state_d = ST_DONE;
          end else begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sdclkl_q <= 1'b0;
      state_q  <= ST_IDLE;
      bcnt_q   <= '0;
      tcnt_q   <= '0;
      sr_q     <= '0;
      tok_q    <= '0;
      inaddr_q <= '0;
      out_q    <= 1'b1;
      oe_q     <= 1'b0;
      wstat_q  <= WSTAT_OK;
    end else begin
      sdclkl_q <= sdclkl_d;
      state_q  <= state_d;
      bcnt_q   <= bcnt_d;
      tcnt_q   <= tcnt_d;
      sr_q     <= sr_d;
      tok_q    <= tok_d;
      inaddr_q <= inaddr_d;
      out_q    <= out_d;
      oe_q     <= oe_d;
      wstat_q  <= wstat_d;
    end
  end

  assign sddat0_out = out_q;
  assign sddat0_oe  = oe_q;
  assign wbusy      = (state_q != ST_IDLE);
  assign wdone      = (state_q == ST_DONE);
  assign wstat      = wstat_q;
  assign inaddr     = inaddr_q;

endmodule

// File: tb/tb_sd_dat_writer.sv
// tb/tb_sd_dat_writer.sv - directed bench for sd_dat_writer
// A second instance with BUSY_TIMEOUT=50 runs timeout cases alongside the main writes.
`timescale 1ns/1ps
module tb_sd_dat_writer;

  logic clk    = 1'b0;
  logic rstn   = 1'b0;
  logic sdclk  = 1'b0;
  logic sd_div = 1'b0;
  int   sdr_cnt = 0;

  logic       wstart1 = 1'b0, wstart2 = 1'b0;
  logic       in1 = 1'b1, in2 = 1'b1;
  logic       out1, oe1, wbusy1, wdone1;
  logic       out2, oe2, wbusy2, wdone2;
  logic [1:0] wstat1, wstat2;
  logic [8:0] inaddr1, inaddr2;
  logic [7:0] inbyte1;
  logic [7:0] inbyte2 = 8'h00;
  int         mode = 0;

  int n_cmp = 0;
  int n_err = 0;

  bit         stream[$];
  logic [8:0] addr_q[$];
  logic       sd_prev = 1'b0;
  logic [8:0] last_addr = '0;
  int         done_cnt1 = 0, done_cnt2 = 0;
  int         done_rise1 = 0, done_rise2 = 0;
  logic [1:0] done_stat1 = '0, done_stat2 = '0;

  sd_dat_writer dut1 (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0_in(in1),
    .sddat0_out(out1), .sddat0_oe(oe1), .wstart(wstart1), .wbusy(wbusy1),
    .wdone(wdone1), .wstat(wstat1), .inaddr(inaddr1), .inbyte(inbyte1)
  );

  sd_dat_writer #(.BUSY_TIMEOUT(50)) dut2 (
    .clk(clk), .rstn(rstn), .sdclk(sdclk), .sddat0_in(in2),
    .sddat0_out(out2), .sddat0_oe(oe2), .wstart(wstart2), .wbusy(wbusy2),
    .wdone(wdone2), .wstat(wstat2), .inaddr(inaddr2), .inbyte(inbyte2)
  );

  always #5 clk = ~clk;

  // sdclk half-period = 2 clk, driven in the clk domain.
  always @(posedge clk) begin
    sd_div <= ~sd_div;
    if (sd_div) begin
      sdclk <= ~sdclk;
      if (!sdclk) sdr_cnt <= sdr_cnt + 1;
    end
  end

  always_comb begin
    case (mode)
      0:       inbyte1 = 8'h00;
      1:       inbyte1 = 8'hFF;
      default: inbyte1 = inaddr1[7:0];
    endcase
  end

  always @(negedge clk) begin
    sd_prev <= sdclk;
    if (sdclk && !sd_prev && oe1) stream.push_back(out1);
    if (inaddr1 != last_addr) addr_q.push_back(inaddr1);
    last_addr <= inaddr1;
    if (wdone1) begin
      done_cnt1  <= done_cnt1 + 1;
      done_stat1 <= wstat1;
      done_rise1 <= sdr_cnt;
    end
    if (wdone2) begin
      done_cnt2  <= done_cnt2 + 1;
      done_stat2 <= wstat2;
      done_rise2 <= sdr_cnt;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] model_byte(input int m, input int k);
    if (m == 0) return 8'h00;
    if (m == 1) return 8'hFF;
    return k[7:0];
  endfunction

  task automatic wait_fall();
    @(negedge sdclk);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_start(input int which);
    @(negedge clk);
    if (which == 0) wstart1 = 1'b1; else wstart2 = 1'b1;
    @(negedge clk);
    if (which == 0) wstart1 = 1'b0; else wstart2 = 1'b0;
  endtask

  task automatic wait_release(input int which, output int r0);
    bit seen_oe = 1'b0;
    bit ok = 1'b0;
    r0 = 0;
    for (int i = 0; i < 6000 && !ok; i++) begin
      wait_fall();
      if ((which == 0 ? oe1 : oe2) == 1'b1) seen_oe = 1'b1;
      else if (seen_oe) begin
        ok = 1'b1;
        r0 = sdr_cnt;
      end
    end
    chk(which == 0 ? "release1" : "release2", ok, 1);
  endtask

  // Card side: start bit, 3 token bits, end bit, busy low bits, then a final level.
  task automatic respond(input int which, input logic [2:0] tok, input int busy_lo, input logic fin);
    bit seq[$];
    seq.push_back(1'b0);
    seq.push_back(tok[2]);
    seq.push_back(tok[1]);
    seq.push_back(tok[0]);
    seq.push_back(1'b1);
    for (int i = 0; i < busy_lo; i++) seq.push_back(1'b0);
    seq.push_back(fin);
    foreach (seq[i]) begin
      if (which == 0) in1 = seq[i]; else in2 = seq[i];
      if (i != seq.size() - 1) wait_fall();
    end
  endtask

  task automatic wait_done(input int which, input int base, input int limit);
    int i = 0;
    while (i < limit && (which == 0 ? done_cnt1 : done_cnt2) == base) begin
      @(negedge clk);
      i++;
    end
    chk(which == 0 ? "done1_seen" : "done2_seen", (i < limit), 1);
  endtask

  task automatic wait_bits(input int n, input string tag);
    int i = 0;
    while (i < 30000 && stream.size() < n) begin
      @(negedge clk);
      i++;
    end
    chk(tag, (stream.size() >= n), 1);
  endtask

  task automatic check_stream(input int m, input bit use_const, input logic [15:0] exp_crc);
    int          errs = 0;
    logic [15:0] field = '0;
    logic [15:0] mcrc = '0;
    logic [7:0]  b;
    logic        bv;
    chk("stream_len", stream.size(), 4116);
    if (stream.size() == 4116) begin
      chk("preamble", {stream[0], stream[1], stream[2]}, 3'b110);
      for (int i = 0; i < 4096; i++) begin
        b  = model_byte(m, i / 8);
        bv = b[7 - (i % 8)];
        if (stream[3 + i] != bv) errs++;
        mcrc = {mcrc[14:0], 1'b0} ^ (((mcrc[15] ^ bv) == 1'b1) ? 16'h1021 : 16'h0000);
      end
      chk("data_bits", errs, 0);
      for (int i = 0; i < 16; i++) field = {field[14:0], stream[4099 + i]};
      if (use_const) chk("crc_const", field, exp_crc);
      chk("crc_model", field, mcrc);
      chk("end_bit", stream[4115], 1);
    end
  endtask

  initial begin
    int r0, r2, base, base2, errs;
    r0 = 0; r2 = 0; errs = 0;

    repeat (3) @(negedge clk);
    chk("rst_oe", oe1, 0);
    chk("rst_out", out1, 1);
    chk("rst_wbusy", wbusy1, 0);
    chk("rst_wdone", wdone1, 0);
    chk("rst_wstat", wstat1, 0);
    chk("rst_inaddr", inaddr1, 0);
    @(negedge clk);
    rstn = 1'b1;

    // Abort at data bit 1000 with an asynchronous reset.
    mode = 1;
    stream.delete();
    pulse_start(0);
    wait_bits(1003, "reach_bit1000");
    base = done_cnt1;
    #2;
    chk("oe_before_rst", oe1, 1);
    rstn = 1'b0;
    #1;
    chk("rst_mid_oe", oe1, 0);
    chk("rst_mid_out", out1, 1);
    chk("rst_mid_wbusy", wbusy1, 0);
    chk("rst_mid_inaddr", inaddr1, 0);
    repeat (4) @(negedge clk);
    chk("rst_mid_no_wdone", done_cnt1 - base, 0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Zeros with 100 busy rises; in parallel, busy timeout on the second instance.
    mode = 0;
    stream.delete();
    base  = done_cnt1;
    base2 = done_cnt2;
    fork
      begin
        pulse_start(0);
        wait_release(0, r0);
        respond(0, 3'b010, 100, 1'b1);
        wait_done(0, base, 2000);
        chk("zeros_wstat", done_stat1, 0);
        chk("zeros_rises", done_rise1 - r0, 106);
        repeat (8) wait_fall();
        chk("zeros_wdone_once", done_cnt1 - base, 1);
      end
      begin
        pulse_start(1);
        wait_release(1, r2);
        respond(1, 3'b010, 0, 1'b0);
        wait_done(1, base2, 2000);
        chk("busy_to_wstat", done_stat2, 3);
        chk("busy_to_rises", done_rise2 - r2, 56);
      end
    join
    in1 = 1'b1;
    in2 = 1'b1;
    check_stream(0, 1'b1, 16'h0000);

    // Ones with immediate busy release; in parallel, CRC-status timeout.
    mode = 1;
    stream.delete();
    base  = done_cnt1;
    base2 = done_cnt2;
    fork
      begin
        pulse_start(0);
        wait_release(0, r0);
        respond(0, 3'b010, 0, 1'b1);
        wait_done(0, base, 2000);
        chk("ones_wstat", done_stat1, 0);
        chk("ones_rises", done_rise1 - r0, 6);
      end
      begin
        pulse_start(1);
        wait_release(1, r2);
        wait_done(1, base2, 2000);
        chk("stat_to_wstat", done_stat2, 3);
        chk("stat_to_rises", done_rise2 - r2, 16);
      end
    join
    in1 = 1'b1;
    check_stream(1, 1'b1, 16'h7FA1);

    // Incrementing bytes, stray wstart in DATA, CRC error token.
    mode = 2;
    stream.delete();
    addr_q.delete();
    base = done_cnt1;
    chk("inc_inaddr_idle", inaddr1, 0);
    pulse_start(0);
    wait_bits(503, "reach_bit500");
    pulse_start(0);
    chk("inc_wbusy_after_wstart", wbusy1, 1);
    wait_release(0, r0);
    respond(0, 3'b101, 0, 1'b1);
    wait_done(0, base, 2000);
    chk("inc_wstat", done_stat1, 1);
    chk("inc_rises", done_rise1 - r0, 5);
    in1 = 1'b1;
    check_stream(2, 1'b0, 16'h0000);
    chk("addr_count", addr_q.size(), 512);
    foreach (addr_q[i]) begin
      if (addr_q[i] != 9'((i + 1) % 512)) errs++;
    end
    chk("addr_order", errs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/sd_dat_writer.md
SD_DAT_WRITER -- requirements
Module: sd_dat_writer

Interface
REQ-001 SHALL have parameter BUSY_TIMEOUT, default 1000000, the maximum number of sdclk rising edges spent in the busy wait.
REQ-002 SHALL have parameter STAT_TIMEOUT, default 16, the maximum number of sdclk rising edges spent waiting for the CRC-status start bit.
REQ-003 Port clk, input, 1 bit: system clock.
REQ-004 Port rstn, input, 1 bit: reset, asynchronous, active-low.
REQ-005 Port sdclk, input, 1 bit: SD clock from the command controller; the same clk domain, half-period of at least 2 clk.
REQ-006 Port sddat0_in, input, 1 bit: DAT0 pad input.
REQ-007 Port sddat0_out, output, 1 bit: DAT0 drive value.
REQ-008 Port sddat0_oe, output, 1 bit: DAT0 output enable.
REQ-009 Port wstart, input, 1 bit: start a block write; a 1-clk pulse, accepted only in IDLE.
REQ-010 Port wbusy, output, 1 bit: high whenever the state is not IDLE.
REQ-011 Port wdone, output, 1 bit: 1-clk completion pulse.
REQ-012 Port wstat, output, 2 bits: result, 0=OK, 1=CRC error token, 2=write error token, 3=timeout; valid when wdone is high and held until the next wstart.
REQ-013 Port inaddr, output, 9 bits: address of the next sector byte to fetch.
REQ-014 Port inbyte, input, 8 bits: sector byte; must be valid within 8 sdclk periods of an inaddr change.

Function
REQ-015 SHALL detect sdclk edges from a registered copy (sdclkl): rise = ~sdclkl&sdclk, fall = sdclkl&~sdclk.
REQ-016 SHALL change sddat0_out/oe only on fall and sample sddat0_in only on rise.
REQ-017 SHALL implement states IDLE, PRE, START, DATA, CRC, ENDB, SWAIT, STAT, BUSY, DONE.
REQ-018 IDLE: on wstart, SHALL set inaddr=0, clear the CRC and counters, and go to PRE; wstart outside IDLE SHALL be ignored.
REQ-019 PRE: SHALL drive oe=1, out=1 for 2 falls, then go to START.
REQ-020 START: on fall, SHALL drive out=0, load inbyte (byte 0) into the shift register, set inaddr=1, and go to DATA.
REQ-021 DATA: SHALL send 4096 bits MSB-first, one per fall.
REQ-022 DATA: at the fall driving bit 7 of byte k (k≥1), SHALL load inbyte and set inaddr=k+1, where inaddr is 9 bits and wraps 511→0 after the last load.
REQ-023 SHALL compute CRC16 (x^16+x^12+x^5+1, init 0) over the data bits only, as they are driven.
REQ-024 CRC: SHALL send the 16 CRC bits MSB-first, then go to ENDB, which drives out=1 for one fall.
REQ-025 SHALL set oe=0 at the fall after ENDB and enter SWAIT.
REQ-026 SWAIT: on a rise with sddat0_in=0, SHALL go to STAT.
REQ-027 SWAIT: after STAT_TIMEOUT rises with no start bit, SHALL set wstat=3 and go to DONE.
REQ-028 STAT: SHALL capture 3 token bits on the next 3 rises, then skip 1 rise (end bit, value ignored).
REQ-029 STAT: token 010 SHALL go to BUSY; token 101 SHALL set wstat=1 and go to DONE; token 110 or any other value SHALL set wstat=2 and go to DONE.
REQ-030 BUSY: on a rise with sddat0_in=1, SHALL set wstat=0 and go to DONE.
REQ-031 BUSY: when the rise count exceeds BUSY_TIMEOUT, SHALL set wstat=3 and go to DONE.
REQ-032 DONE: SHALL assert wdone for exactly 1 clk and return to IDLE in the same cycle.
REQ-033 oe SHALL be 0 in IDLE, SWAIT, STAT, BUSY and DONE.

Reset
REQ-034 On rstn low, outputs SHALL be: state=IDLE, sddat0_oe=0, sddat0_out=1, wbusy=0, wdone=0, wstat=0, inaddr=0.
REQ-035 On rstn low, internal state SHALL be: counters=0, CRC=0, sdclkl=0.
REQ-036 Reset mid-transfer SHALL release DAT0 asynchronously with no wdone pulse.

Structure
REQ-037 Package sd_pkg SHALL hold the state encoding, the wstat codes, the token constants (010, 101, 110) and the CRC16 polynomial.
REQ-038 A sub-module sd_crc16 SHALL provide the bit-serial CRC with ports clk, rstn, clr, en, din and crc[15:0].

Verification
REQ-039 SHALL cover: 512×0x00, responder token 010, busy 100 rises → CRC field 0x0000, wstat=0, wdone once.
REQ-040 SHALL cover: 512×0xFF, token 010, no busy → CRC field 0x7FA1, wstat=0.
REQ-041 SHALL cover: incrementing bytes, token 101 → wstat=1, no busy wait, inaddr sequence 0..511 observed in order.
REQ-042 SHALL cover: DAT0 held high after ENDB → wdone after 16 rises, wstat=3; DAT0 held low in BUSY with BUSY_TIMEOUT=50 → wstat=3.
REQ-043 SHALL cover: wstart pulsed during DATA → ignored, bit stream unchanged.
REQ-044 SHALL cover: rstn low at data bit 1000 → oe=0 immediately; a new write after reset completes normally.
